fpu_op_sequencer: RTL and testbench
===================================

FPU_OP_SEQUENCER -- requirements
Module: fpu_op_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64, meaning maximum cycles EXEC waits for op_done (range 2..255).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  sequencer can accept a request.
REQ-006 in_a, in_b  input  32  IEEE-754 single operands.
REQ-007 in_func  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-008 align_en  output  1  one-cycle strobe: datapath latches exponent-aligned operands.
REQ-009 op_start  output  1  one-cycle strobe: start arithmetic unit.
REQ-010 op_done  input  1  arithmetic unit result ready (single-cycle pulse).
REQ-011 norm_en  output  1  one-cycle strobe: datapath latches normalised result.
REQ-012 dp_result  input  32  normalised datapath result, valid in the cycle after norm_en.
REQ-013 op_a, op_b, op_func  output  32/32/2  registered operands and function driven to datapath.
REQ-014 out_valid  output  1  response present.
REQ-015 out_ready  input  1  consumer accepts response.
REQ-016 out_result  output  32  response value.
REQ-017 out_exc  output  2  00 none, 01 operand exception, 10 timeout.

Function
REQ-018 States SHALL be IDLE, CHECK, ALIGN, EXEC, NORM, CAPT, RESP; in_ready SHALL be 1 only in IDLE.
REQ-019 IDLE: in_valid=1 SHALL register in_a/in_b/in_func into op_a/op_b/op_func and go to CHECK next cycle.
REQ-020 CHECK (1 cycle): exception SHALL be (op_a[30:23]==8'hFF) or (op_b[30:23]==8'hFF) or (op_func==11 and op_b[30:23]==0).
REQ-021 CHECK with exception -> RESP, out_result=32'h7FC00000, out_exc=01; else add/sub -> ALIGN, mul/div -> EXEC.
REQ-022 ALIGN: align_en=1 for exactly one cycle, then EXEC.
REQ-023 EXEC: op_start=1 in first EXEC cycle only; SHALL stay in EXEC until op_done=1, then NORM.
REQ-024 op_done in the same cycle as op_start SHALL be accepted (minimum EXEC length 1 cycle); op_done outside EXEC SHALL be ignored.
REQ-025 NORM: norm_en=1 one cycle, then CAPT; CAPT SHALL register dp_result into out_result, out_exc=00, then RESP.
REQ-026 RESP: out_valid=1, outputs held stable until out_ready=1; handshake cycle returns to IDLE.
REQ-027 Latency in_valid-accept to out_valid: add/sub 5 cycles + op_done wait, mul/div 4 + wait, exception 2.
REQ-028 No back-to-back overlap: new request only accepted in IDLE (cycle after RESP handshake earliest).
REQ-029 All strobe outputs SHALL be registered-free decodes of state, glitch-free, and 0 outside their state.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE; out_valid, align_en, op_start, norm_en =0; out_result, op_a, op_b =0; op_func, out_exc =00; timeout counter =0.
REQ-031 Reset mid-operation SHALL abandon the operation with no response; a late op_done after reset SHALL be ignored.
REQ-032 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-033 Macro FPU_SEQ_TIMEOUT_EN defined: 8-bit counter cleared on EXEC entry, increments per EXEC cycle; reaching TIMEOUT_CYC without op_done -> RESP, out_result=32'h7FC00000, out_exc=10.
REQ-034 FPU_SEQ_TIMEOUT_EN undefined: no counter, EXEC waits indefinitely, out_exc never 10; TIMEOUT_CYC unused.

Verification
REQ-035 add 3F800000+40000000, op_done 2 cycles after op_start, dp_result=40400000 -> align_en, op_start, norm_en each one pulse; out_result=40400000, exc=00.
REQ-036 mul with in_a=7F800000 -> no align_en/op_start; out_valid 2 cycles after accept, result 7FC00000, exc=01.
REQ-037 div in_b=00000000 -> exc=01; div in_b=3F800000 -> normal EXEC path, no align_en.
REQ-038 out_ready held 0 for 10 cycles in RESP -> out_valid/out_result stable, in_ready=0, new in_valid ignored.
REQ-039 TIMEOUT_EN, TIMEOUT_CYC=8, op_done never -> RESP after 8 EXEC cycles, exc=10; undefined build -> remains in EXEC.
REQ-040 rst_n pulsed low during EXEC, op_done arrives after -> all outputs reset values, no out_valid, in_ready=1.

Source files
------------

// File: rtl/fpu_op_sequencer_if.sv
// fpu_op_sequencer_if
//   Bundles the request, datapath-control and response signals of the FPU
//   operation sequencer.
//   slave  : the sequencer side (takes requests, drives datapath strobes,
//            produces responses).
//   master : the environment side (requester, datapath and consumer).
//   Signals:
//     in_valid/in_ready, in_a, in_b, in_func : request handshake and payload
//     align_en, op_start, norm_en            : datapath strobes
//     op_done, dp_result                     : arithmetic unit / datapath returns
//     op_a, op_b, op_func                    : registered operands to datapath
//     out_valid/out_ready, out_result, out_exc : response handshake and payload
interface fpu_op_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [1:0]  in_func;
    logic        align_en;
    logic        op_start;
    logic        op_done;
    logic        norm_en;
    logic [31:0] dp_result;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [1:0]  op_func;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [1:0]  out_exc;

    modport slave (
        input  in_valid, in_a, in_b, in_func, op_done, dp_result, out_ready,
        output in_ready, align_en, op_start, norm_en, op_a, op_b, op_func,
               out_valid, out_result, out_exc
    );

    modport master (
        output in_valid, in_a, in_b, in_func, op_done, dp_result, out_ready,
        input  in_ready, align_en, op_start, norm_en, op_a, op_b, op_func,
               out_valid, out_result, out_exc
    );
endinterface

// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer
//   Sequences one single-precision FPU operation at a time:
//   IDLE -> CHECK -> [ALIGN for add/sub] -> EXEC -> NORM -> CAPT -> RESP.
//   Operands with an all-ones exponent, or a divide by a zero-exponent
//   divisor, skip the datapath and answer quiet NaN with exc=01.
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : fpu_op_sequencer_if.slave (request, datapath strobes, response)
//   Parameter:
//     TIMEOUT_CYC : max EXEC cycles waiting for op_done (2..255), only used
//                   when FPU_SEQ_TIMEOUT_EN is defined.
//   Optional feature macro: FPU_SEQ_TIMEOUT_EN -- EXEC watchdog that answers
//   quiet NaN with exc=10 if op_done does not arrive in time.
module fpu_op_sequencer #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    fpu_op_sequencer_if.slave  bus
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {IDLE, CHECK, ALIGN, EXEC, NORM, CAPT, RESP} state_t;

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_cfg
        $error("TIMEOUT_CYC must be in 2..255");
    end

    state_t      state, state_nxt;
    logic [31:0] op_a_q, op_b_q, res_q, res_nxt;
    logic [1:0]  func_q, exc_q, exc_nxt;
    logic        exec_first;
    logic        operand_exc;
    logic        tmo_hit;

    assign operand_exc = (op_a_q[30:23] == 8'hFF) || (op_b_q[30:23] == 8'hFF) ||
                         ((func_q == 2'b11) && (op_b_q[30:23] == 8'h00));

`ifdef FPU_SEQ_TIMEOUT_EN
    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_CYC);
    logic [7:0] tmo_cnt;

    // Counts EXEC cycles already spent; the cycle that would bring the
    // count to TMO_LIM is the last one op_done can still be accepted in.
    assign tmo_hit = (state == EXEC) && ((tmo_cnt + 8'd1) == TMO_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= 8'd0;
        else if (state != EXEC)
            tmo_cnt <= 8'd0;
        else
            tmo_cnt <= tmo_cnt + 8'd1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        res_nxt   = res_q;
        exc_nxt   = exc_q;
        case (state)
            IDLE:  if (bus.in_valid) state_nxt = CHECK;
            CHECK: begin
                if (operand_exc) begin
                    state_nxt = RESP;
                    res_nxt   = QNAN;
                    exc_nxt   = 2'b01;
                end else if (func_q[1]) begin
                    state_nxt = EXEC;
                end else begin
                    state_nxt = ALIGN;
                end
            end
            ALIGN: state_nxt = EXEC;
            EXEC: begin
                // op_done wins over a timeout landing in the same cycle
                if (bus.op_done) begin
                    state_nxt = NORM;
                end else if (tmo_hit) begin
                    state_nxt = RESP;
                    res_nxt   = QNAN;
                    exc_nxt   = 2'b10;
                end
            end
            NORM:  state_nxt = CAPT;
            CAPT: begin
                state_nxt = RESP;
                res_nxt   = bus.dp_result;
                exc_nxt   = 2'b00;
            end
            RESP:  if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_a_q     <= 32'd0;
            op_b_q     <= 32'd0;
            func_q     <= 2'b00;
            res_q      <= 32'd0;
            exc_q      <= 2'b00;
            exec_first <= 1'b0;
        end else begin
            state      <= state_nxt;
            res_q      <= res_nxt;
            exc_q      <= exc_nxt;
            exec_first <= (state_nxt == EXEC) && (state != EXEC);
            if (state == IDLE && bus.in_valid) begin
                op_a_q <= bus.in_a;
                op_b_q <= bus.in_b;
                func_q <= bus.in_func;
            end
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.align_en   = (state == ALIGN);
    assign bus.op_start   = (state == EXEC) && exec_first;
    assign bus.norm_en    = (state == NORM);
    assign bus.out_valid  = (state == RESP);
    assign bus.op_a       = op_a_q;
    assign bus.op_b       = op_b_q;
    assign bus.op_func    = func_q;
    assign bus.out_result = res_q;
    assign bus.out_exc    = exc_q;
endmodule

// File: tb/tb_fpu_op_sequencer.sv
module tb_fpu_op_sequencer;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_op_sequencer_if bus();

    fpu_op_sequencer #(.TIMEOUT_CYC(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: what one transaction must look like from the outside.
    // lat counts cycles from the accept edge to the first out_valid cycle.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                         input int dly, input logic [31:0] dp,
                         output int lat, output int n_al, output int n_st, output int n_nm,
                         output logic [31:0] res, output logic [1:0] exc);
        bit bad;
        bit addsub;
        bit tmo;
        bad    = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF) || (f == 2'b11 && b[30:23] == 8'h00);
        addsub = (f < 2'b10);
        tmo    = 1'b0;
`ifdef FPU_SEQ_TIMEOUT_EN
        tmo = (dly >= TMO);
`endif
        if (bad) begin
            lat = 2; n_al = 0; n_st = 0; n_nm = 0; res = 32'h7FC00000; exc = 2'b01;
        end else if (tmo) begin
            lat = (addsub ? 3 : 2) + TMO; n_al = addsub ? 1 : 0; n_st = 1; n_nm = 0;
            res = 32'h7FC00000; exc = 2'b10;
        end else begin
            lat = (addsub ? 5 : 4) + dly + 1; n_al = addsub ? 1 : 0; n_st = 1; n_nm = 1;
            res = dp; exc = 2'b00;
        end
    endtask

    // Called at a negedge with the sequencer idle; returns at a negedge idle.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                           input int dly, input logic [31:0] dp, input int hold);
        int lat, n_al, n_st, n_nm, e_lat, e_al, e_st, e_nm, cyc, s;
        bit started, sent, seen;
        logic [31:0] e_res;
        logic [1:0]  e_exc;
        model(a, b, f, dly, dp, e_lat, e_al, e_st, e_nm, e_res, e_exc);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_a = a; bus.in_b = b; bus.in_func = f; bus.dp_result = dp;
        bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a = $urandom; bus.in_b = $urandom;
        n_al = 0; n_st = 0; n_nm = 0; lat = 0; s = 0;
        started = 0; sent = 0; seen = 0;
        cyc = 1;
        for (int k = 0; k < 200; k++) begin
            bus.op_done = 1'b0;
            if (bus.align_en) n_al++;
            if (bus.norm_en)  n_nm++;
            if (bus.op_start) begin n_st++; s = cyc; started = 1; end
            if (bus.out_valid) begin lat = cyc; seen = 1; break; end
            if (started && !sent && cyc == s + dly) begin bus.op_done = 1'b1; sent = 1; end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        bus.op_done = 1'b0;
        if (!seen) begin
            chk("resp_timeout", 32'd0, 32'd1);
            return;
        end
        chk("latency", 32'(lat), 32'(e_lat));
        chk("align_cnt", 32'(n_al), 32'(e_al));
        chk("start_cnt", 32'(n_st), 32'(e_st));
        chk("norm_cnt", 32'(n_nm), 32'(e_nm));
        chk("out_result", bus.out_result, e_res);
        chk("out_exc", 32'(bus.out_exc), 32'(e_exc));
        chk("op_a", bus.op_a, a);
        chk("op_b", bus.op_b, b);
        chk("op_func", 32'(bus.op_func), 32'(f));
        // Back-pressure: response must hold, new requests and stray op_done ignored.
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.op_done  = (h == 1);
            @(posedge clk); @(negedge clk);
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_result", bus.out_result, e_res);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_strobes", {29'd0, bus.align_en, bus.op_start, bus.norm_en}, 32'd0);
        end
        bus.in_valid = 1'b0; bus.op_done = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.out_ready = 1'b0;
        chk("post_hs_valid", 32'(bus.out_valid), 32'd0);
        chk("post_hs_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic rand_operand(output logic [31:0] v, input bit allow_zero_exp);
        v = $urandom;
        case ($urandom_range(0, 7))
            0: v[30:23] = 8'hFF;
            1: if (allow_zero_exp) v[30:23] = 8'h00;
            default: ;
        endcase
    endtask

    initial begin
        logic [31:0] a, b;
        bit ok;
        bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.in_func = 0;
        bus.op_done = 0; bus.dp_result = 0; bus.out_ready = 0;
        #2;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_strobes", {29'd0, bus.align_en, bus.op_start, bus.norm_en}, 32'd0);
        chk("rst_op_a", bus.op_a, 32'd0);
        chk("rst_out", {bus.out_result[29:0], bus.out_exc}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_in_ready", 32'(bus.in_ready), 32'd1);

        run_txn(32'h3F800000, 32'h40000000, 2'b00, 2, 32'h40400000, 0);
        run_txn(32'h7F800000, 32'h3F800000, 2'b10, 0, 32'h12345678, 0);
        run_txn(32'h3F800000, 32'h00000000, 2'b11, 0, 32'h12345678, 0);
        run_txn(32'h40000000, 32'h3F800000, 2'b11, 0, 32'h40000000, 0);
        run_txn(32'h40000000, 32'h7F800001, 2'b01, 3, 32'h55555555, 10);
        run_txn(32'h3F000000, 32'h3F000000, 2'b01, 1, 32'hBF000000, 10);
        // No op_done for a long time: waits, or times out in the watchdog build.
        run_txn(32'h3F800000, 32'h3F800000, 2'b00, 30, 32'h40000000, 0);
        run_txn(32'h3F800000, 32'h3F800000, 2'b10, TMO - 1, 32'h3F800000, 0);
        run_txn(32'h3F800000, 32'h3F800000, 2'b10, TMO, 32'h3F800000, 0);

        for (int i = 0; i < 40; i++) begin
            rand_operand(a, 1'b1);
            rand_operand(b, 1'b1);
            run_txn(a, b, 2'($urandom_range(0, 3)), $urandom_range(0, 12), $urandom,
                    $urandom_range(0, 3));
        end

        // Reset in the middle of EXEC, then a late op_done.
        bus.in_a = 32'h3F800000; bus.in_b = 32'h40000000; bus.in_func = 2'b10;
        bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.op_start) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("rst_test_start", 32'(ok), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", {28'd0, bus.in_ready, bus.out_valid, bus.op_start, bus.norm_en}, 32'h8);
        chk("mid_rst_regs", bus.op_a | bus.op_b | bus.out_result, 32'd0);
        chk("mid_rst_codes", {28'd0, bus.op_func, bus.out_exc}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.op_done = 1'b1;
        @(negedge clk);
        bus.op_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("post_rst_quiet", {28'd0, bus.in_ready, bus.out_valid, bus.norm_en, bus.align_en}, 32'h8);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
